// File: rtl/calc_seq.sv
// -----------------------------------------------------------------------------
// calc_seq - multi-cycle arithmetic sequencer for the switch calculator.
//
// One operation is accepted per start request while idle. Both operands are
// clipped to 0..99 on capture. Add and subtract complete in a single cycle;
// multiply (shift-add) and divide (restoring) each take seven iterations, so
// no wide combinational multiplier/divider array is needed.
//
// Ports:
//   iCLK     in   1   system clock, rising edge
//   iRST_N   in   1   asynchronous active-low reset
//   iA       in   7   operand A (unsigned), sampled at start acceptance
//   iB       in   7   operand B (unsigned), sampled at start acceptance
//   iOP      in   2   00 add, 01 subtract, 10 multiply, 11 divide
//   iSTART   in   1   start request, level-sampled in IDLE
//   oBUSY    out  1   high whenever the sequencer is not idle
//   oDONE    out  1   one-cycle pulse, result valid
//   oRESULT  out  14  registered result
//   oTYPE    out  2   display format code for the BCD splitter
//   oERR     out  1   divide-by-zero flag for the last operation
// -----------------------------------------------------------------------------
module calc_seq (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [6:0]  iA,
    input  logic [6:0]  iB,
    input  logic [1:0]  iOP,
    input  logic        iSTART,
    output logic        oBUSY,
    output logic        oDONE,
    output logic [13:0] oRESULT,
    output logic [1:0]  oTYPE,
    output logic        oERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] TYPE_PLAIN = 2'b00;
    localparam logic [1:0] TYPE_NEG1  = 2'b01;
    localparam logic [1:0] TYPE_NEG2  = 2'b10;
    localparam logic [1:0] TYPE_QR    = 2'b11;

    localparam logic [6:0] OPND_MAX   = 7'd99;
    localparam logic [2:0] LAST_ITER  = 3'd6;

    state_t      state_q, state_d;
    logic [6:0]  a_q, a_d;
    logic [6:0]  b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [13:0] acc_q, acc_d;
    logic [7:0]  rem_q, rem_d;
    logic [6:0]  quo_q, quo_d;
    logic [13:0] result_q, result_d;
    logic [1:0]  type_q, type_d;
    logic        err_q, err_d;
    logic        busy_q;
    logic        done_q;

    logic [6:0]  a_clip_s;
    logic [6:0]  b_clip_s;
    logic [13:0] acc_next_s;
    logic [7:0]  rem_shift_s;
    logic        rem_ge_s;
    logic [7:0]  rem_next_s;
    logic [6:0]  quo_next_s;

    // Operand clipping and the datapath for one multiply/divide iteration.
    always_comb begin
        a_clip_s = (iA > OPND_MAX) ? OPND_MAX : iA;
        b_clip_s = (iB > OPND_MAX) ? OPND_MAX : iB;

        // Shift-add: bit cnt of A selects B shifted by cnt.
        if (a_q[cnt_q]) begin
            acc_next_s = acc_q + ({7'd0, b_q} << cnt_q);
        end else begin
            acc_next_s = acc_q;
        end

        // Restoring divide: dividend enters MSB first, so iteration i uses A[6-i].
        rem_shift_s = {rem_q[6:0], a_q[LAST_ITER - cnt_q]};
        rem_ge_s    = (rem_shift_s >= {1'b0, b_q});
        if (rem_ge_s) begin
            rem_next_s = rem_shift_s - {1'b0, b_q};
        end else begin
            rem_next_s = rem_shift_s;
        end
        quo_next_s = {quo_q[5:0], rem_ge_s};
    end

    // Next-state and result logic of the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        type_d   = type_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    a_d   = a_clip_s;
                    b_d   = b_clip_s;
                    op_d  = iOP;
                    cnt_d = 3'd0;
                    acc_d = 14'd0;
                    rem_d = 8'd0;
                    quo_d = 7'd0;
                    case (iOP)
                        OP_ADD: begin
                            result_d = {6'd0, ({1'b0, a_clip_s} + {1'b0, b_clip_s})};
                            type_d   = TYPE_PLAIN;
                            err_d    = 1'b0;
                            state_d  = S_DONE;
                        end
                        OP_SUB: begin
                            if (a_clip_s >= b_clip_s) begin
                                result_d = {7'd0, (a_clip_s - b_clip_s)};
                                type_d   = TYPE_PLAIN;
                            end else begin
                                result_d = {7'd0, (b_clip_s - a_clip_s)};
                                // Single negative digit fits the 1-digit format.
                                if ((b_clip_s - a_clip_s) <= 7'd9) begin
                                    type_d = TYPE_NEG1;
                                end else begin
                                    type_d = TYPE_NEG2;
                                end
                            end
                            err_d   = 1'b0;
                            state_d = S_DONE;
                        end
                        OP_MUL: begin
                            state_d = S_EXEC;
                        end
                        OP_DIV: begin
                            if (b_clip_s == 7'd0) begin
                                result_d = 14'd0;
                                type_d   = TYPE_PLAIN;
                                err_d    = 1'b1;
                                state_d  = S_DONE;
                            end else begin
                                state_d = S_EXEC;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_EXEC: begin
                cnt_d = cnt_q + 3'd1;
                if (op_q == OP_MUL) begin
                    acc_d = acc_next_s;
                end else begin
                    rem_d = rem_next_s;
                    quo_d = quo_next_s;
                end
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = 3'd0;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                    if (op_q == OP_MUL) begin
                        result_d = acc_next_s;
                        type_d   = TYPE_PLAIN;
                    end else begin
                        result_d = {quo_next_s, rem_next_s[6:0]};
                        type_d   = TYPE_QR;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= S_IDLE;
            a_q      <= 7'd0;
            b_q      <= 7'd0;
            op_q     <= 2'b00;
            cnt_q    <= 3'd0;
            acc_q    <= 14'd0;
            rem_q    <= 8'd0;
            quo_q    <= 7'd0;
            result_q <= 14'd0;
            type_q   <= 2'b00;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            type_q   <= type_d;
            err_q    <= err_d;
            // Flags are derived from the next state so they line up with state_q.
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign oBUSY   = busy_q;
    assign oDONE   = done_q;
    assign oRESULT = result_q;
    assign oTYPE   = type_q;
    assign oERR    = err_q;

endmodule

// File: tb/tb_calc_seq.sv
// -----------------------------------------------------------------------------
// tb_calc_seq - directed self-checking bench for calc_seq.
// -----------------------------------------------------------------------------
module tb_calc_seq;

    logic        iCLK;
    logic        iRST_N;
    logic [6:0]  iA;
    logic [6:0]  iB;
    logic [1:0]  iOP;
    logic        iSTART;
    logic        oBUSY;
    logic        oDONE;
    logic [13:0] oRESULT;
    logic [1:0]  oTYPE;
    logic        oERR;

    int checks = 0;
    int errors = 0;
    int lat;
    int bcnt;
    int dcnt;

    calc_seq dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iA      (iA),
        .iB      (iB),
        .iOP     (iOP),
        .iSTART  (iSTART),
        .oBUSY   (oBUSY),
        .oDONE   (oDONE),
        .oRESULT (oRESULT),
        .oTYPE   (oTYPE),
        .oERR    (oERR)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one start pulse and measure latency to oDONE (cycles after the
    // accepting edge) and number of cycles oBUSY is sampled high.
    task automatic run_op(input logic [6:0] a, input logic [6:0] b, input logic [1:0] op,
                          output int latency, output int busy_cycles);
        @(negedge iCLK);
        iA = a; iB = b; iOP = op; iSTART = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        iSTART = 1'b0;
        latency = 0;
        busy_cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            if (oBUSY) busy_cycles++;
            if (oDONE) begin
                latency = i;
                break;
            end
            @(negedge iCLK);
        end
        @(negedge iCLK);
        if (oBUSY) busy_cycles++;
        chk("done_low_after", {31'd0, oDONE}, 32'd0);
    endtask

    initial begin
        iRST_N = 1'b0;
        iA = 7'd0; iB = 7'd0; iOP = 2'b00; iSTART = 1'b0;
        repeat (3) @(negedge iCLK);
        chk("rst_result", {18'd0, oRESULT}, 32'd0);
        chk("rst_busy",   {31'd0, oBUSY},   32'd0);
        chk("rst_done",   {31'd0, oDONE},   32'd0);
        chk("rst_err",    {31'd0, oERR},    32'd0);
        iRST_N = 1'b1;

        // Add 45+67
        run_op(7'd45, 7'd67, 2'b00, lat, bcnt);
        chk("add_lat",  lat, 32'd1);
        chk("add_busy", bcnt, 32'd1);
        chk("add_res",  {18'd0, oRESULT}, 32'd112);
        chk("add_type", {30'd0, oTYPE}, 32'd0);

        // Subtracts
        run_op(7'd12, 7'd57, 2'b01, lat, bcnt);
        chk("sub1_res",  {18'd0, oRESULT}, 32'd45);
        chk("sub1_type", {30'd0, oTYPE}, 32'd2);
        run_op(7'd5, 7'd9, 2'b01, lat, bcnt);
        chk("sub2_res",  {18'd0, oRESULT}, 32'd4);
        chk("sub2_type", {30'd0, oTYPE}, 32'd1);
        run_op(7'd80, 7'd30, 2'b01, lat, bcnt);
        chk("sub3_res",  {18'd0, oRESULT}, 32'd50);
        chk("sub3_type", {30'd0, oTYPE}, 32'd0);
        run_op(7'd1, 7'd10, 2'b01, lat, bcnt);
        chk("sub4_res",  {18'd0, oRESULT}, 32'd9);
        chk("sub4_type", {30'd0, oTYPE}, 32'd1);
        run_op(7'd0, 7'd10, 2'b01, lat, bcnt);
        chk("sub5_res",  {18'd0, oRESULT}, 32'd10);
        chk("sub5_type", {30'd0, oTYPE}, 32'd2);

        // Multiplies
        run_op(7'd99, 7'd99, 2'b10, lat, bcnt);
        chk("mul1_lat",  lat, 32'd8);
        chk("mul1_busy", bcnt, 32'd8);
        chk("mul1_res",  {18'd0, oRESULT}, 32'd9801);
        chk("mul1_type", {30'd0, oTYPE}, 32'd0);
        run_op(7'd120, 7'd2, 2'b10, lat, bcnt);
        chk("mul2_res",  {18'd0, oRESULT}, 32'd198);

        // Divides
        run_op(7'd97, 7'd7, 2'b11, lat, bcnt);
        chk("div1_lat",  lat, 32'd8);
        chk("div1_res",  {18'd0, oRESULT}, 32'd1670);
        chk("div1_type", {30'd0, oTYPE}, 32'd3);
        chk("div1_err",  {31'd0, oERR}, 32'd0);
        run_op(7'd3, 7'd50, 2'b11, lat, bcnt);
        chk("div2_res",  {18'd0, oRESULT}, 32'd3);

        // Divide by zero, then a clean add clears the error
        run_op(7'd40, 7'd0, 2'b11, lat, bcnt);
        chk("dz_lat",  lat, 32'd1);
        chk("dz_res",  {18'd0, oRESULT}, 32'd0);
        chk("dz_type", {30'd0, oTYPE}, 32'd0);
        chk("dz_err",  {31'd0, oERR}, 32'd1);
        run_op(7'd1, 7'd1, 2'b00, lat, bcnt);
        chk("add11_res", {18'd0, oRESULT}, 32'd2);
        chk("add11_err", {31'd0, oERR}, 32'd0);

        // Input changes and a start pulse during EXEC must be ignored
        @(negedge iCLK);
        iA = 7'd99; iB = 7'd99; iOP = 2'b10; iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        dcnt = 0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) begin
                iA = 7'd5; iOP = 2'b00; iSTART = 1'b1;
            end else begin
                iSTART = 1'b0;
            end
            if (oDONE) dcnt++;
            @(negedge iCLK);
        end
        chk("ign_dones", dcnt, 32'd1);
        chk("ign_res",   {18'd0, oRESULT}, 32'd9801);

        // Divide to set nonzero outputs, then reset during a multiply
        run_op(7'd97, 7'd7, 2'b11, lat, bcnt);
        chk("pre_rst_type", {30'd0, oTYPE}, 32'd3);
        @(negedge iCLK);
        iA = 7'd10; iB = 7'd10; iOP = 2'b10; iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        chk("mrst_result", {18'd0, oRESULT}, 32'd0);
        chk("mrst_type",   {30'd0, oTYPE},   32'd0);
        chk("mrst_busy",   {31'd0, oBUSY},   32'd0);
        chk("mrst_done",   {31'd0, oDONE},   32'd0);
        chk("mrst_err",    {31'd0, oERR},    32'd0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (oDONE) dcnt++;
            @(negedge iCLK);
        end
        chk("mrst_no_done", dcnt, 32'd0);
        run_op(7'd6, 7'd7, 2'b10, lat, bcnt);
        chk("post_rst_lat", lat, 32'd8);
        chk("post_rst_res", {18'd0, oRESULT}, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_seq.md
# calc_seq

Multi-cycle arithmetic sequencer for the switch calculator. It accepts one operation per start pulse and clips both operands to 0..99. Add and subtract finish in one cycle. Multiply runs as a 7-step shift-add, and divide runs as a 7-step restoring divide. The result goes out as a registered 14-bit value plus the 2-bit display-format code used by the BCD splitter. It sits between the switch inputs and the splitter/7-segment path, replacing the combinational ALU so multiply and divide need no wide combinational arrays.

## Interface
- No parameters; widths fixed: operands 7 bits, result 14 bits.
- iCLK  in  1  system clock; all state changes on its rising edge.
- iRST_N  in  1  reset, asynchronous, active-low.
- iA  in  7  operand A, unsigned, sampled only at start acceptance.
- iB  in  7  operand B, unsigned, sampled only at start acceptance.
- iOP  in  2  operation, sampled at start acceptance: 00 add, 01 subtract, 10 multiply, 11 divide.
- iSTART  in  1  start request, level-sampled.
- oBUSY  out  1  high whenever state is not IDLE.
- oDONE  out  1  one-cycle pulse; result valid.
- oRESULT  out  14  registered result.
- oTYPE  out  2  display format: 00 plain 4-digit, 01 negative 1-digit, 10 negative 2-digit, 11 quotient/remainder pair.
- oERR  out  1  divide-by-zero flag for the last operation.

## Operation
- States: IDLE, EXEC, DONE.
- **IDLE, iSTART=1 at an edge:** capture A=min(iA,99), B=min(iB,99) and op.
- **Add:** result A+B, type 00; go to DONE.
- **Subtract:**
  - A>=B: result A-B, type 00.
  - A<B: result B-A; type 01 if B-A<=9, else 10.
  - Go to DONE.
- **Divide with B=0:** result 0, type 00, oERR=1; go to DONE.
- **Multiply or divide with B!=0:** load iteration counter=0; go to EXEC.
- **Multiply in EXEC:** 14-bit accumulator starts at 0. Iteration i (0..6): if A[i], acc += B<<i. Result = acc (max 9801), type 00.
- **Divide in EXEC:** 8-bit partial remainder R starts at 0; dividend shifts MSB-first. Each iteration: R = {R[6:0], next dividend bit}; if R>=B, then R-=B and quotient bit=1, else 0. Result = {Q[6:0], R[6:0]}, i.e. Q*128+R, type 11.
- **Leaving EXEC:** on the edge that performs iteration 6, load oRESULT/oTYPE/oERR and go to DONE.
- **DONE:** oDONE=1 for exactly one cycle, then IDLE unconditionally.
- iSTART is ignored in EXEC and DONE; no queuing.
- oRESULT, oTYPE and oERR change only on entry to DONE and hold until the next DONE entry.
- oERR clears on any non-error completion.
- Intermediate accumulator and remainder values are never visible on outputs.

## Timing
- Reset (asynchronous, any state including mid-EXEC): state IDLE, counter 0, accumulator/remainder 0, oRESULT=0, oTYPE=00, oERR=0, oDONE=0, oBUSY=0. The aborted operation produces no oDONE.
- Start accepted at edge k:
  - Add, subtract, or divide-by-zero: DONE after edge k; oDONE high in cycle k+1; IDLE after edge k+1.
  - Multiply or divide: iterations on edges k+1..k+7; oDONE high in cycle k+8; IDLE after edge k+8.
- Throughput: next start accepted no earlier than edge k+2 (single-cycle ops) or k+9 (multi-cycle ops).
- iSTART held high continuously: a new operation starts each time IDLE is reached.
- oBUSY rises in the cycle after acceptance and falls in the cycle after oDONE.
- Operand or op changes after edge k have no effect on the running operation.

## Test plan
- Reset, then A=45, B=67, op 00, one-cycle start pulse -> oDONE in the next cycle, oRESULT=112, oTYPE=00, oBUSY high exactly 1 cycle.
- Subtract A=12, B=57 -> oRESULT=45, oTYPE=10. Then A=5, B=9 -> oRESULT=4, oTYPE=01. Then A=80, B=30 -> oRESULT=50, oTYPE=00.
- Multiply A=99, B=99 -> oDONE exactly 8 cycles after acceptance, oRESULT=9801, oTYPE=00. Multiply A=120 (clipped), B=2 -> oRESULT=198.
- Divide A=97, B=7 -> oRESULT=1670 (Q=13, R=6), oTYPE=11, oERR=0. Divide A=3, B=50 -> oRESULT=3.
- Divide A=40, B=0 -> oDONE next cycle, oRESULT=0, oERR=1. A following add 1+1 -> oERR=0, oRESULT=2.
- Start multiply, change iA/iOP and pulse iSTART during EXEC -> original result, single oDONE. Separately, assert iRST_N=0 at iteration 3 -> all outputs 0 immediately, no oDONE; a later start works normally.
